// File: rtl/pipe_barrel_shifter.sv
// rtl/pipe_barrel_shifter.sv - pipelined barrel shifter (SRL/SRA/SLL/ROR) with valid/ready flow control
// A register closes every REG_EVERY mux levels; the final level is always registered.
module pipe_barrel_shifter #(
  parameter int  WIDTH     = 32,
  parameter int  REG_EVERY = 2,
  localparam int SHW       = $clog2(WIDTH),
  localparam int L         = (SHW + REG_EVERY - 1) / REG_EVERY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  // Applies mux levels lo..hi-1; level k moves the word by 2^k when sh[k] is set.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   sh,
    input logic [1:0]       op,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] rr;
    r  = d;
    rr = '0;
    for (int k = 0; k < SHW; k++) begin
      if (k >= lo && k < hi && sh[k]) begin
        case (op)
          OP_SRL:  r = r >> (1 << k);
          OP_SRA:  r = $signed(r) >>> (1 << k);
          OP_SLL:  r = r << (1 << k);
          default: begin
            rr = {r, r} >> (1 << k);
            r  = rr[WIDTH-1:0];
          end
        endcase
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0] data_q  [L];
  logic [SHW-1:0]   shamt_q [L];
  logic [1:0]       op_q    [L];
  logic [L-1:0]     valid_q;
  logic             zero_q;

  logic [WIDTH-1:0] st_data  [L];
  logic [SHW-1:0]   st_shamt [L];
  logic [1:0]       st_op    [L];
  logic [WIDTH-1:0] nxt_data [L];
  logic [L-1:0]     st_valid;
  logic [L-1:0]     en;
  logic             blocked;

  always_comb begin
    st_valid = '0;
    for (int s = 0; s < L; s++) begin
      if (s == 0) begin
        st_data[s]  = in_data;
        st_shamt[s] = in_shamt;
        st_op[s]    = in_op;
        st_valid[s] = in_valid;
      end else begin
        st_data[s]  = data_q[s-1];
        st_shamt[s] = shamt_q[s-1];
        st_op[s]    = op_q[s-1];
        st_valid[s] = valid_q[s-1];
      end
      nxt_data[s] = shift_levels(st_data[s], st_shamt[s], st_op[s],
                                 s * REG_EVERY, (s + 1) * REG_EVERY);
    end
  end

  // A stage is stuck only if it and every stage after it are full and the consumer stalls.
  always_comb begin
    blocked = !out_ready;
    en      = '0;
    for (int s = L - 1; s >= 0; s--) begin
      blocked = blocked & valid_q[s];
      en[s]   = !blocked;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      for (int s = 0; s < L; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        if (en[s]) begin
          valid_q[s] <= st_valid[s];
          data_q[s]  <= nxt_data[s];
          shamt_q[s] <= st_shamt[s];
          op_q[s]    <= st_op[s];
        end
      end
      if (en[L-1]) begin
        zero_q <= (nxt_data[L-1] == '0);
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb/tb_pipe_barrel_shifter.sv - directed and randomized self-checking bench for pipe_barrel_shifter
module tb_pipe_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;

  int checks = 0;
  int passed = 0;

  pipe_barrel_shifter #(.WIDTH(32), .REG_EVERY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Whole-amount reference shift.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] n);
    int sh;
    sh = int'(n);
    case (op)
      2'b00:   return a >> sh;
      2'b01:   return a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
      2'b10:   return a << sh;
      default: return (a >> sh) | ((sh == 0) ? 32'h0 : (a << (32 - sh)));
    endcase
  endfunction

  task automatic single(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] n, input logic [31:0] exp_d, input logic exp_z);
    int cyc;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = a;
    in_shamt  = n;
    out_ready = 1'b1;
    #3;
    check({tag, " in_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    cyc      = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 3);
    check({tag, " data"}, out_data, exp_d);
    check({tag, " zero"}, 32'(out_zero), 32'(exp_z));
    @(posedge clk); #1;
    check({tag, " drained"}, 32'(out_valid), 0);
  endtask

  logic [1:0]  b_op [5];
  logic [31:0] b_a  [5];
  logic [4:0]  b_n  [5];
  logic [31:0] b_exp[5];
  logic [31:0] held;
  logic [31:0] q[$];
  logic [31:0] e;
  logic [31:0] prev_data;
  logic        prev_zero;
  logic        prev_stall;

  initial begin
    int ins, outs, first, acc, cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", out_data, 0);
    check("reset out_zero", 32'(out_zero), 0);
    check("reset in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    single("srl msb 31", 2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    single("srl by 0",   2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    single("sra neg 4",  2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
    single("sra pos 4",  2'b01, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0);
    single("sra ones 31",2'b01, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0);
    single("sra sign 31",2'b01, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b0);
    single("sra by 0",   2'b01, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0);
    single("sll 1 by 31",2'b10, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    single("sll to zero",2'b10, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1);
    single("sll by 0",   2'b10, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0);
    single("ror 1 by 1", 2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0);
    single("ror by 8",   2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
    single("ror by 0",   2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);

    // Backpressure: five ops against a stalled consumer, then release.
    for (int i = 0; i < 5; i++) begin
      b_op[i]  = 2'(i % 4);
      b_a[i]   = $urandom;
      b_n[i]   = 5'($urandom_range(1, 31));
      b_exp[i] = ref_shift(b_op[i], b_a[i], b_n[i]);
    end
    ins   = 0;
    outs  = 0;
    first = -1;
    held  = '0;
    for (int c = 0; c < 30 && outs < 5; c++) begin
      in_valid = (ins < 5);
      if (ins < 5) begin
        in_op    = b_op[ins];
        in_data  = b_a[ins];
        in_shamt = b_n[ins];
      end
      out_ready = (c >= 6);
      #3;
      if (c == 3) held = out_data;
      if (c == 5) begin
        check("bp accepted", ins, 3);
        check("bp in_ready", 32'(in_ready), 0);
        check("bp out_valid", 32'(out_valid), 1);
        check("bp hold", out_data, held);
        check("bp first", out_data, b_exp[0]);
      end
      if (out_valid && out_ready) begin
        check("bp order", out_data, b_exp[outs]);
        if (first < 0) first = c;
        else check("bp gap", c, first + outs);
        outs++;
      end
      if (in_valid && in_ready) ins++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp count", outs, 5);
    @(posedge clk); #1;

    // Reset with three ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom);
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst no stale", 32'(out_valid), 0);
    end

    // Random stream against the queue model.
    acc        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_zero  = 1'b0;
    while ((acc < 10000 || q.size() > 0) && cyc < 60000) begin
      in_valid = (acc < 10000) && ($urandom_range(3) != 0);
      in_op    = 2'($urandom);
      in_shamt = 5'($urandom);
      case ($urandom_range(7))
        0:       in_data = 32'h0;
        1:       in_data = 32'hFFFF_FFFF;
        2:       in_data = 32'h8000_0000;
        default: in_data = $urandom;
      endcase
      out_ready = ($urandom_range(3) != 0);
      #3;
      if (prev_stall) begin
        check("rnd stall valid", 32'(out_valid), 1);
        check("rnd stall data", out_data, prev_data);
        check("rnd stall zero", 32'(out_zero), 32'(prev_zero));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd spurious", 32'(out_valid), 0);
        end else begin
          e = q.pop_front();
          check("rnd data", out_data, e);
          check("rnd zero", 32'(out_zero), 32'(e == 32'h0));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(in_op, in_data, in_shamt));
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_zero  = out_zero;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd accepted", acc, 10000);
    check("rnd drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
